// File: rtl/ecc_rmw_sequencer.sv
// rtl/ecc_rmw_sequencer.sv - RAM port sequencer that turns ECC partial writes into read-modify-write
module ecc_rmw_sequencer #(
    parameter int DATA_W     = 20,
    parameter int ADDR_W     = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_ecc_enable_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_data_i,
    input  logic [DATA_W-1:0] req_bitmask_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic [DATA_W-1:0] ram_bitmask_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic [15:0]       rmw_count_o
);

    localparam logic [DATA_W-1:0] ALL_ONES = '1;
    localparam logic [2:0]        LAT_LOAD = 3'(RD_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_MERGE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_req_ready, w_req_ready_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_data, w_rsp_data_nxt;
    logic              r_ram_en, w_ram_en_nxt;
    logic              r_ram_we, w_ram_we_nxt;
    logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_nxt;
    logic [DATA_W-1:0] r_ram_wdata, w_ram_wdata_nxt;
    logic [DATA_W-1:0] r_ram_mask, w_ram_mask_nxt;
    logic [15:0]       r_rmw_count, w_rmw_count_nxt;
    logic [2:0]        r_lat_cnt, w_lat_cnt_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic [DATA_W-1:0] r_mask, w_mask_nxt;
    logic              r_rmw, w_rmw_nxt;

    logic              w_accept;
    logic              w_full_mask;
    logic              w_is_wr;
    logic              w_is_rmw;
    logic [DATA_W-1:0] w_merged;

    // Request classification happens on the live inputs; only the outcome is kept.
    assign w_accept    = req_valid_i & r_req_ready;
    assign w_full_mask = (req_bitmask_i == ALL_ONES);
    assign w_is_wr     = req_we_i & (~cfg_ecc_enable_i | w_full_mask);
    assign w_is_rmw    = req_we_i & cfg_ecc_enable_i & ~w_full_mask;
    assign w_merged    = (ram_rdata_i & ~r_mask) | (r_data & r_mask);

    // Next-state and next-output decode; every output is the registered copy of its next value.
    always_comb begin
        w_state_nxt     = r_state;
        w_req_ready_nxt = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_data_nxt  = r_rsp_data;
        w_ram_en_nxt    = 1'b0;
        w_ram_we_nxt    = 1'b0;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_wdata_nxt = r_ram_wdata;
        w_ram_mask_nxt  = r_ram_mask;
        w_rmw_count_nxt = r_rmw_count;
        w_lat_cnt_nxt   = r_lat_cnt;
        w_data_nxt      = r_data;
        w_mask_nxt      = r_mask;
        w_rmw_nxt       = r_rmw;
        case (r_state)
            S_IDLE: begin
                w_req_ready_nxt = 1'b1;
                if (w_accept) begin
                    w_req_ready_nxt = 1'b0;
                    w_data_nxt      = req_data_i;
                    w_mask_nxt      = req_bitmask_i;
                    w_rmw_nxt       = w_is_rmw;
                    w_ram_en_nxt    = 1'b1;
                    w_ram_addr_nxt  = req_addr_i;
                    if (w_is_wr) begin
                        w_state_nxt     = S_WRITE;
                        w_ram_we_nxt    = 1'b1;
                        w_ram_wdata_nxt = req_data_i;
                        w_ram_mask_nxt  = cfg_ecc_enable_i ? ALL_ONES : req_bitmask_i;
                    end else begin
                        w_state_nxt = S_READ;
                    end
                end
            end
            S_WRITE: begin
                w_state_nxt     = S_IDLE;
                w_req_ready_nxt = 1'b1;
            end
            S_READ: begin
                w_state_nxt   = S_WAIT;
                w_lat_cnt_nxt = LAT_LOAD;
            end
            S_WAIT: begin
                w_lat_cnt_nxt = r_lat_cnt - 3'd1;
                // Counter reaching zero marks the cycle the RAM data is valid.
                if (r_lat_cnt == 3'd1) begin
                    if (r_rmw) begin
                        w_state_nxt     = S_MERGE;
                        w_ram_en_nxt    = 1'b1;
                        w_ram_we_nxt    = 1'b1;
                        w_ram_wdata_nxt = w_merged;
                        w_ram_mask_nxt  = ALL_ONES;
                    end else begin
                        w_state_nxt     = S_IDLE;
                        w_req_ready_nxt = 1'b1;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_data_nxt  = ram_rdata_i;
                    end
                end
            end
            S_MERGE: begin
                w_state_nxt     = S_IDLE;
                w_req_ready_nxt = 1'b1;
                if (r_rmw_count != 16'hFFFF) begin
                    w_rmw_count_nxt = r_rmw_count + 16'd1;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_req_ready_nxt = 1'b1;
            end
        endcase
    end

    // State and output registers; reset abandons any sequence in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_mask  <= '0;
            r_rmw_count <= '0;
            r_lat_cnt   <= '0;
            r_data      <= '0;
            r_mask      <= '0;
            r_rmw       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_ram_en    <= w_ram_en_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
            r_ram_mask  <= w_ram_mask_nxt;
            r_rmw_count <= w_rmw_count_nxt;
            r_lat_cnt   <= w_lat_cnt_nxt;
            r_data      <= w_data_nxt;
            r_mask      <= w_mask_nxt;
            r_rmw       <= w_rmw_nxt;
        end
    end

    assign req_ready_o   = r_req_ready;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_data_o    = r_rsp_data;
    assign ram_en_o      = r_ram_en;
    assign ram_we_o      = r_ram_we;
    assign ram_addr_o    = r_ram_addr;
    assign ram_wdata_o   = r_ram_wdata;
    assign ram_bitmask_o = r_ram_mask;
    assign rmw_count_o   = r_rmw_count;

endmodule
